// File: rtl/fetch_pc_pkg.sv
// fetch_pc_pkg: shared width types (common) and fetch-stage types/constants (pipes)
package common;
    typedef logic [63:0] u64;
    typedef logic [31:0] u32;
endpackage

package pipes;
    import common::*;
    typedef enum logic [1:0] {FETCH, DROP, HOLD} fetch_state_t;
    typedef struct packed {
        logic valid;
        u64   pc;
        u32   instr;
        logic misalign;
    } fetch_data_t;
    localparam u64 PC_RESET  = 64'h0000_0000_8000_0000;
    localparam u32 NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/fetch_pc_skid.sv
// fetch_skid: one-entry skid buffer holding a fetched {pc, instr} while decode stalls
module fetch_skid
    import pipes::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        drain,
    input  logic        flush,
    input  fetch_data_t in_d,
    output fetch_data_t out_q
);
    fetch_data_t data_d, data_q;

    always_comb begin
        data_d       = data_q;
        data_d.valid = data_q.valid & ~drain;
        data_d       = load ? in_d : data_d;
        data_d       = flush ? '0 : data_d;
    end

    always_ff @(posedge clk) data_q <= reset ? '0 : data_d;

    assign out_q = data_q;
endmodule

// File: rtl/fetch_pc.sv
// fetch_pc: fetch-stage PC sequencer with skid-buffered fetch/decode slot; FETCH_MISALIGN_CHECK_EN enables misaligned-fetch markers
module fetch_pc
    import common::*;
    import pipes::*;
#(
    parameter u64 RESET_PC = PC_RESET
) (
    input  logic clk,
    input  logic reset,
    input  logic redirect_valid,
    input  u64   redirect_pc,
    input  logic stall,
    output logic ireq_valid,
    output u64   ireq_addr,
    input  logic iresp_data_ok,
    input  u32   iresp_data,
    output logic fd_valid,
    output u64   fd_pc,
    output u32   fd_instr,
    output logic fd_misalign
);
    fetch_state_t state_d, state_q;
    u64           pc_d, pc_q, pend_d, pend_q, tgt;
    fetch_data_t  fd_d, fd_q, fetched, skid_q;
    logic         mis, ok, free, skid_load, skid_drain, skid_flush;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign mis = state_q == FETCH && pc_q[1:0] != 2'b00;
    assign tgt = redirect_pc;
`else
    assign mis = 1'b0;
    assign tgt = redirect_pc & ~u64'(3);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            fd_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            fd_q    <= fd_d;
        end
    end

    always_comb begin
        ok         = iresp_data_ok | mis;
        free       = !fd_q.valid || !stall;
        fetched    = '{1'b1, pc_q, mis ? NOP_INSTR : iresp_data, mis};
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        fd_d       = fd_q;
        fd_d.valid = fd_q.valid && stall && !redirect_valid;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_flush = 1'b0;
        case (state_q)
            FETCH: begin
                if (redirect_valid) begin
                    pc_d    = ok ? tgt : pc_q;
                    pend_d  = ok ? pend_q : tgt;
                    state_d = ok ? FETCH : DROP;
                end else if (ok) begin
                    pc_d      = pc_q + 64'd4;
                    fd_d      = free ? fetched : fd_d;
                    skid_load = !free;
                    state_d   = free ? FETCH : HOLD;
                end
            end
            DROP: begin
                pend_d  = redirect_valid ? tgt : pend_q;
                pc_d    = ok ? (redirect_valid ? tgt : pend_q) : pc_q;
                state_d = ok ? FETCH : DROP;
            end
            HOLD: begin
                if (redirect_valid) begin
                    skid_flush = 1'b1;
                    pc_d       = tgt;
                    state_d    = FETCH;
                end else if (!stall) begin
                    fd_d       = skid_q;
                    skid_drain = 1'b1;
                    state_d    = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        ireq_valid  = state_q != HOLD && !mis;
        ireq_addr   = pc_q;
        fd_valid    = fd_q.valid;
        fd_pc       = fd_q.pc;
        fd_instr    = fd_q.instr;
        fd_misalign = fd_q.misalign;
    end

    fetch_skid u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .drain (skid_drain),
        .flush (skid_flush),
        .in_d  (fetched),
        .out_q (skid_q)
    );
endmodule

// File: tb/tb_fetch_pc.sv
// tb_fetch_pc: directed self-checking bench for fetch_pc with a variable-latency bus model
module tb_fetch_pc;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        fd_valid;
    logic [63:0] fd_pc;
    logic [31:0] fd_instr;
    logic        fd_misalign;
    int          lat = 0;
    int          wait_cnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign iresp_data_ok = ireq_valid && wait_cnt == lat;
    assign iresp_data    = ireq_addr[31:0] ^ 32'h5A5A_0000;

    always @(posedge clk) wait_cnt <= (!ireq_valid || iresp_data_ok) ? 0 : wait_cnt + 1;

    fetch_pc dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .fd_valid       (fd_valid),
        .fd_pc          (fd_pc),
        .fd_instr       (fd_instr),
        .fd_misalign    (fd_misalign)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("rst_fd_valid", fd_valid, 0);
        chk("rst_fd_pc", fd_pc, 0);
        chk("rst_fd_instr", fd_instr, 0);
        chk("rst_fd_misalign", fd_misalign, 0);
        chk("rst_ireq_valid", ireq_valid, 1);
        chk("rst_ireq_addr", ireq_addr, 64'h8000_0000);
        tick();
        chk("c1_fd_valid", fd_valid, 1);
        chk("c1_fd_pc", fd_pc, 64'h8000_0000);
        chk("c1_fd_instr", fd_instr, 32'hDA5A_0000);
        chk("c1_ireq_addr", ireq_addr, 64'h8000_0004);
        tick();
        chk("c2_fd_valid", fd_valid, 1);
        chk("c2_fd_pc", fd_pc, 64'h8000_0004);
        chk("c2_ireq_addr", ireq_addr, 64'h8000_0008);
        tick();
        chk("c3_fd_pc", fd_pc, 64'h8000_0008);
        chk("c3_ireq_addr", ireq_addr, 64'h8000_000C);
        stall = 1'b1;
        tick();
        chk("stall1_fd_valid", fd_valid, 1);
        chk("stall1_fd_pc", fd_pc, 64'h8000_0008);
        chk("stall1_ireq_valid", ireq_valid, 0);
        tick();
        chk("stall2_fd_pc", fd_pc, 64'h8000_0008);
        chk("stall2_ireq_valid", ireq_valid, 0);
        stall = 1'b0;
        tick();
        chk("drain_fd_valid", fd_valid, 1);
        chk("drain_fd_pc", fd_pc, 64'h8000_000C);
        chk("drain_fd_instr", fd_instr, 32'hDA5A_000C);
        chk("drain_ireq_valid", ireq_valid, 1);
        chk("drain_ireq_addr", ireq_addr, 64'h8000_0010);
        tick();
        chk("after_drain_fd_pc", fd_pc, 64'h8000_0010);
        chk("after_drain_ireq_addr", ireq_addr, 64'h8000_0014);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_1000;
        tick();
        redirect_valid = 1'b0;
        chk("redir_ok_fd_valid", fd_valid, 0);
        chk("redir_ok_ireq_addr", ireq_addr, 64'h8000_1000);
        tick();
        chk("redir_ok_fd_pc", fd_pc, 64'h8000_1000);
        chk("redir_ok_fd_instr", fd_instr, 32'hDA5A_1000);
        chk("lat_ireq_addr0", ireq_addr, 64'h8000_1004);
        lat = 3;
        tick();
        chk("lat_ireq_addr1", ireq_addr, 64'h8000_1004);
        chk("lat_fd_valid1", fd_valid, 0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_2000;
        tick();
        redirect_valid = 1'b0;
        chk("drop_ireq_valid", ireq_valid, 1);
        chk("drop_ireq_addr2", ireq_addr, 64'h8000_1004);
        tick();
        chk("drop_ireq_addr3", ireq_addr, 64'h8000_1004);
        chk("drop_data_ok", iresp_data_ok, 1);
        tick();
        chk("drop_fd_valid", fd_valid, 0);
        chk("drop_next_addr", ireq_addr, 64'h8000_2000);
        lat = 0;
        tick();
        chk("tgt_fd_pc", fd_pc, 64'h8000_2000);
        chk("tgt_fd_valid", fd_valid, 1);
        stall = 1'b1;
        tick();
        chk("hold_ireq_valid", ireq_valid, 0);
        chk("hold_fd_pc", fd_pc, 64'h8000_2000);
        stall          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_3000;
        tick();
        redirect_valid = 1'b0;
        chk("hold_redir_fd_valid", fd_valid, 0);
        chk("hold_redir_ireq_valid", ireq_valid, 1);
        chk("hold_redir_ireq_addr", ireq_addr, 64'h8000_3000);
        tick();
        chk("hold_redir_fd_pc", fd_pc, 64'h8000_3000);
        chk("hold_redir_fd_instr", fd_instr, 32'hDA5A_3000);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_4002;
        tick();
        redirect_valid = 1'b0;
        chk("mis_fd_valid0", fd_valid, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis_ireq_valid", ireq_valid, 0);
        tick();
        chk("mis_fd_valid", fd_valid, 1);
        chk("mis_fd_misalign", fd_misalign, 1);
        chk("mis_fd_instr", fd_instr, 32'h0000_0013);
        chk("mis_fd_pc", fd_pc, 64'h8000_4002);
        chk("mis_ireq_valid_again", ireq_valid, 0);
`else
        chk("align_ireq_addr", ireq_addr, 64'h8000_4000);
        chk("align_ireq_valid", ireq_valid, 1);
        tick();
        chk("align_fd_pc", fd_pc, 64'h8000_4000);
        chk("align_fd_misalign", fd_misalign, 0);
        chk("align_fd_instr", fd_instr, 32'hDA5A_4000);
`endif
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_ireq_addr0", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_ireq_valid", ireq_valid, 1);
        tick();
        chk("wrap_ireq_addr1", ireq_addr, 64'h0);
        chk("wrap_fd_pc", fd_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_fd_misalign", fd_misalign, 0);
        lat = 3;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_fd_valid", fd_valid, 0);
        chk("midrst_ireq_valid", ireq_valid, 1);
        chk("midrst_ireq_addr", ireq_addr, 64'h8000_0000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
